branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Produces the next-PC control the PC register consumes: a 2-bit control code (pc_ctrl) and a redirect target (pc_in).
- Takes decoded branch and jump instructions plus operand values, evaluates each condition and computes the target.
- Honours the MIPS single branch-delay slot: the redirect is issued only after the delay-slot instruction has been accepted.
- Sits between decode/register-read and the PC register. It also drives the link write for JAL, JALR, BLTZAL and BGEZAL.

Parameters:
- RESET_VECTOR, 32'hBFC00000, value shown on pc_in while idle and after reset.
- HALT_ADDR, 32'h00000000, register-jump target that ends execution and sets halted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  decode presents one instruction this cycle (accepted on the same cycle)
- br_op  in  4  branch class, br_op_t from the package
- instr_pc  in  32  address of the presented instruction
- rs_val  in  32  value of register rs
- rt_val  in  32  value of register rt
- imm16  in  16  branch offset field
- jidx  in  26  J-type index field
- rd_idx  in  5  destination register for JALR
- pc_ctrl  out  2  next-PC code: 0 = sequential, 1 = branch, 2 = jump, 3 = register jump
- pc_in  out  32  redirect target
- link_we  out  1  link write strobe
- link_reg  out  5  link destination register
- link_val  out  32  link value, instr_pc + 8
- halted  out  1  a register jump to HALT_ADDR has taken effect
- slot_err  out  1  a branch was found in a delay slot (sticky)

Behaviour:
- Reset (asynchronous, rst_n low) drives:
  - pc_ctrl = 0, pc_in = RESET_VECTOR, link_we = 0, link_reg = 0, link_val = 0
  - halted = 0, slot_err = 0
  - state = IDLE, pending target cleared
- Reset asserted mid-operation abandons any pending redirect.
- States: IDLE, SLOT, REDIRECT, HALT.
- Target arithmetic, all 32-bit, wraps modulo 2^32, no overflow trap:
  - branch target = instr_pc + 4 + (sign-extended imm16 << 2)
  - jump target = {(instr_pc + 4)[31:28], jidx, 2'b00}
  - register target = rs_val
- Branch conditions:
  - BEQ: rs == rt. BNE: rs != rt.
  - BLEZ: signed rs <= 0. BGTZ: signed rs > 0.
  - BLTZ and BLTZAL: signed rs < 0. BGEZ and BGEZAL: signed rs >= 0.
  - J, JAL, JR and JALR are always taken.
- IDLE:
  - Outputs pc_ctrl = 0.
  - instr_valid with br_op = NONE: stay in IDLE.
  - instr_valid with a not-taken branch: stay in IDLE.
  - instr_valid with a taken branch or jump: latch the target and its code (1, 2 or 3), then go to SLOT on the next edge.
- Link write:
  - Link ops (JAL, JALR, BLTZAL, BGEZAL) pulse link_we for exactly one cycle after acceptance.
  - link_val = instr_pc + 8 for all link ops.
  - link_reg = 31, except JALR, which uses rd_idx.
  - BLTZAL and BGEZAL write the link even when not taken.
- SLOT:
  - pc_ctrl stays 0; the delay slot is fetched sequentially.
  - The next instr_valid is taken as the delay-slot instruction; go to REDIRECT.
  - If that instruction has br_op != NONE: set slot_err and ignore it as a branch (no target, no link).
  - No instr_valid: wait in SLOT indefinitely.
- REDIRECT:
  - For exactly one cycle: pc_ctrl = the latched code, pc_in = the latched target.
  - instr_valid is ignored in this cycle; decode must not present an instruction here.
  - Next state is IDLE.
  - If the code is 3 and the target equals HALT_ADDR, the next state is HALT instead.
- HALT:
  - pc_ctrl = 3 and pc_in = HALT_ADDR, held.
  - halted = 1.
  - All inputs are ignored; only reset exits.
- Latency: the redirect appears two edges after the branch is accepted, provided the delay slot follows back-to-back.
- pc_in holds its last value whenever pc_ctrl = 0.

Decomposition:
- Shared package mips_cpu_pkg:
  - br_op_t enum: NONE, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL, JR, JALR
  - pc_ctrl_t constants: PC_SEQ = 0, PC_BRANCH = 1, PC_JUMP = 2, PC_JREG = 3
  - constant LINK_REG_RA = 31
- One combinational sub-module, branch_cond_eval: takes br_op, rs_val and rt_val and returns taken and is_link. Target arithmetic and the FSM stay in the top module.

Test Plan:
- BEQ taken: instr_pc = BFC00010, rs = rt = 5, imm16 = 0004, then the delay slot on the next cycle → the cycle after the slot shows pc_ctrl = 1, pc_in = BFC00024; then pc_ctrl = 0.
- BNE not taken (rs = rt = 7) → pc_ctrl stays 0, no SLOT entry, link_we = 0.
- JAL at instr_pc = BFC00100 with jidx = 0000040 → link_we pulse, link_reg = 31, link_val = BFC00108; after the slot, pc_ctrl = 2, pc_in = B0000100.
- BLTZ with rs = 80000000 (negative) and imm16 = FFFF at instr_pc = BFC00020 → pc_in = BFC00020.
- Delay slot delayed 3 cycles, and a BEQ placed in the slot → no redirect until the slot is accepted; slot_err = 1; only the first target is applied.
- JR with rs_val = 0 → REDIRECT with pc_ctrl = 3 and pc_in = 0; halted = 1 on the following cycle and held. Asserting rst_n = 0 mid-SLOT on another run returns all outputs to reset values immediately.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared types and constants for the MIPS front-end control blocks.
//   br_op_t     : decoded branch/jump class presented by decode
//   pc_ctrl_t   : next-PC control code consumed by the PC register
//   bru_state_t : branch resolve unit sequencing states
//   pc_code()   : maps a branch class to the redirect code it produces
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    NONE   = 4'd0,
    BEQ    = 4'd1,
    BNE    = 4'd2,
    BLEZ   = 4'd3,
    BGTZ   = 4'd4,
    BLTZ   = 4'd5,
    BGEZ   = 4'd6,
    BLTZAL = 4'd7,
    BGEZAL = 4'd8,
    J      = 4'd9,
    JAL    = 4'd10,
    JR     = 4'd11,
    JALR   = 4'd12
  } br_op_t;

  typedef logic [1:0] pc_ctrl_t;

  localparam pc_ctrl_t PC_SEQ    = 2'd0;
  localparam pc_ctrl_t PC_BRANCH = 2'd1;
  localparam pc_ctrl_t PC_JUMP   = 2'd2;
  localparam pc_ctrl_t PC_JREG   = 2'd3;

  localparam logic [4:0] LINK_REG_RA = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SLOT     = 2'd1,
    S_REDIRECT = 2'd2,
    S_HALT     = 2'd3
  } bru_state_t;

  // Redirect code for a taken op: PC-relative branches, absolute-region
  // jumps, and register jumps each steer the PC mux differently.
  function automatic pc_ctrl_t pc_code(input br_op_t op);
    pc_ctrl_t code;
    case (op)
      J, JAL:   code = PC_JUMP;
      JR, JALR: code = PC_JREG;
      NONE:     code = PC_SEQ;
      default:  code = PC_BRANCH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Combinational condition evaluation for one decoded branch/jump.
//   br_op   in  4  branch class
//   rs_val  in  32 value of register rs
//   rt_val  in  32 value of register rt
//   taken   out 1  the op redirects the PC
//   is_link out 1  the op writes a return address (regardless of taken)
// ---------------------------------------------------------------------------
module branch_cond_eval
  import mips_cpu_pkg::*;
(
  input  br_op_t      br_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken,
  output logic        is_link
);

  logic signed [31:0] rs_s;
  logic               rs_neg;
  logic               rs_zero;

  assign rs_s    = $signed(rs_val);
  assign rs_neg  = (rs_s < 32'sd0);
  assign rs_zero = (rs_val == 32'd0);

  always_comb begin
    taken   = 1'b0;
    is_link = 1'b0;
    case (br_op)
      BEQ:    taken = (rs_val == rt_val);
      BNE:    taken = (rs_val != rt_val);
      BLEZ:   taken = rs_neg | rs_zero;
      BGTZ:   taken = ~rs_neg & ~rs_zero;
      BLTZ:   taken = rs_neg;
      BGEZ:   taken = ~rs_neg;
      BLTZAL: begin
        taken   = rs_neg;
        is_link = 1'b1;
      end
      BGEZAL: begin
        taken   = ~rs_neg;
        is_link = 1'b1;
      end
      J:      taken = 1'b1;
      JAL: begin
        taken   = 1'b1;
        is_link = 1'b1;
      end
      JR:     taken = 1'b1;
      JALR: begin
        taken   = 1'b1;
        is_link = 1'b1;
      end
      default: begin
        taken   = 1'b0;
        is_link = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves decoded branches/jumps into next-PC control, honouring the single
// MIPS branch-delay slot, and issues the link-register write.
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid           decode presents an instruction (accepted same cycle)
//   br_op                 branch class of that instruction
//   instr_pc              its address
//   rs_val, rt_val        operand values
//   imm16, jidx, rd_idx   branch offset, J-type index, JALR destination
//   pc_ctrl, pc_in        next-PC code and redirect target
//   link_we/_reg/_val     one-cycle link write (return address instr_pc + 8)
//   halted                a register jump to HALT_ADDR has taken effect
//   slot_err              sticky: a branch appeared in a delay slot
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  br_op_t      br_op,
  input  logic [31:0] instr_pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [4:0]  rd_idx,
  output logic [1:0]  pc_ctrl,
  output logic [31:0] pc_in,
  output logic        link_we,
  output logic [4:0]  link_reg,
  output logic [31:0] link_val,
  output logic        halted,
  output logic        slot_err
);

  bru_state_t  state_q;
  bru_state_t  state_d;

  logic        taken;
  logic        is_link;

  logic        accept_idle;
  logic        accept_slot;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] tgt_d;

  // Pending redirect, held from branch acceptance until REDIRECT.
  logic [31:0] tgt_p1;
  pc_ctrl_t    code_p1;

  logic [31:0] pc_in_q;
  logic        link_we_q;
  logic [4:0]  link_reg_q;
  logic [31:0] link_val_q;
  logic        slot_err_q;

  branch_cond_eval u_cond (
    .br_op   (br_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .taken   (taken),
    .is_link (is_link)
  );

  assign accept_idle = instr_valid && (state_q == S_IDLE);
  assign accept_slot = instr_valid && (state_q == S_SLOT);

  // Target arithmetic (all modulo 2^32)
  assign pc_plus4 = instr_pc + 32'd4;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = {pc_plus4[31:28], jidx, 2'b00};

  always_comb begin
    tgt_d = br_tgt;
    case (pc_code(br_op))
      PC_JUMP: tgt_d = j_tgt;
      PC_JREG: tgt_d = rs_val;
      default: tgt_d = br_tgt;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and PC control outputs
  always_comb begin
    state_d = state_q;
    pc_ctrl = PC_SEQ;
    case (state_q)
      S_IDLE: begin
        if (accept_idle && taken) state_d = S_SLOT;
      end
      S_SLOT: begin
        // Any instruction here is the delay slot, whatever its class.
        if (instr_valid) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        pc_ctrl = code_p1;
        if ((code_p1 == PC_JREG) && (tgt_p1 == HALT_ADDR)) begin
          state_d = S_HALT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        pc_ctrl = PC_JREG;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
        pc_ctrl = PC_SEQ;
      end
    endcase
  end

  // Latch redirect, drive pc_in and link write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_p1     <= 32'd0;
      code_p1    <= PC_SEQ;
      pc_in_q    <= RESET_VECTOR;
      link_we_q  <= 1'b0;
      link_reg_q <= 5'd0;
      link_val_q <= 32'd0;
      slot_err_q <= 1'b0;
    end else begin
      if (accept_idle && taken) begin
        tgt_p1  <= tgt_d;
        code_p1 <= pc_code(br_op);
      end

      // pc_in is loaded one edge early so it already carries the target in
      // REDIRECT, then simply holds while pc_ctrl is sequential.
      if (accept_slot) begin
        pc_in_q <= tgt_p1;
        if (br_op != NONE) slot_err_q <= 1'b1;
      end

      // Conditional link ops write the return address even when not taken.
      link_we_q <= accept_idle && is_link;
      if (accept_idle && is_link) begin
        link_reg_q <= (br_op == JALR) ? rd_idx : LINK_REG_RA;
        link_val_q <= instr_pc + 32'd8;
      end
    end
  end

  assign pc_in    = (state_q == S_HALT) ? HALT_ADDR : pc_in_q;
  assign halted   = (state_q == S_HALT);
  assign link_we  = link_we_q;
  assign link_reg = link_reg_q;
  assign link_val = link_val_q;
  assign slot_err = slot_err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scoreboard bench: the stimulus process runs a behavioural model that pushes
// expected redirects and link writes into queues; a negedge monitor pops and
// compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;
  import mips_cpu_pkg::*;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] HA = 32'h00000000;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] tgt;
  } redir_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] v;
  } link_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  br_op_t      br_op = NONE;
  logic [31:0] instr_pc = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] jidx = '0;
  logic [4:0]  rd_idx = '0;
  logic [1:0]  pc_ctrl;
  logic [31:0] pc_in;
  logic        link_we;
  logic [4:0]  link_reg;
  logic [31:0] link_val;
  logic        halted;
  logic        slot_err;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .RESET_VECTOR (RV),
    .HALT_ADDR    (HA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .br_op       (br_op),
    .instr_pc    (instr_pc),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .imm16       (imm16),
    .jidx        (jidx),
    .rd_idx      (rd_idx),
    .pc_ctrl     (pc_ctrl),
    .pc_in       (pc_in),
    .link_we     (link_we),
    .link_reg    (link_reg),
    .link_val    (link_val),
    .halted      (halted),
    .slot_err    (slot_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  redir_t rq[$];
  link_t  lq[$];

  // Reference model state
  bit          mslot = 0;
  bit          mhalt = 0;
  logic [1:0]  mcode = '0;
  logic [31:0] mtgt = '0;
  bit          exp_slot_err = 0;
  bit          exp_halted = 0;
  logic [31:0] last_pc = RV;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic bit m_taken(input br_op_t op, input logic [31:0] rs, input logic [31:0] rt);
    int srs;
    srs = int'($signed(rs));
    case (op)
      BEQ:            return rs == rt;
      BNE:            return rs != rt;
      BLEZ:           return srs <= 0;
      BGTZ:           return srs > 0;
      BLTZ, BLTZAL:   return srs < 0;
      BGEZ, BGEZAL:   return srs >= 0;
      J, JAL, JR, JALR: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic bit m_link(input br_op_t op);
    return (op == JAL) || (op == JALR) || (op == BLTZAL) || (op == BGEZAL);
  endfunction

  function automatic logic [1:0] m_code(input br_op_t op);
    if (op == J || op == JAL) return 2'd2;
    if (op == JR || op == JALR) return 2'd3;
    return 2'd1;
  endfunction

  function automatic logic [31:0] m_target(input br_op_t op, input logic [31:0] pc,
                                           input logic [31:0] rs, input logic [15:0] imm,
                                           input logic [25:0] ji);
    logic [31:0] nxt;
    int          off;
    nxt = pc + 32'd4;
    if (op == J || op == JAL) return {nxt[31:28], ji, 2'b00};
    if (op == JR || op == JALR) return rs;
    off = int'($signed(imm)) * 4;
    return nxt + 32'(off);
  endfunction

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_pc = RV;
    end else begin
      chk("halted", 32'(halted), 32'(exp_halted));
      chk("slot_err", 32'(slot_err), 32'(exp_slot_err));
      if (exp_halted) begin
        chk("halt_pc_ctrl", 32'(pc_ctrl), 32'd3);
        chk("halt_pc_in", pc_in, HA);
      end else if (pc_ctrl != 2'd0) begin
        if (rq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL redirect_unexpected: got pc_ctrl=%0d pc_in=%h, required no redirect",
                   pc_ctrl, pc_in);
        end else begin
          redir_t r;
          r = rq.pop_front();
          chk("redirect_code", 32'(pc_ctrl), 32'(r.code));
          chk("redirect_target", pc_in, r.tgt);
          last_pc = r.tgt;
        end
      end else begin
        chk("pc_in_hold", pc_in, last_pc);
      end
      if (link_we) begin
        if (lq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL link_unexpected: got link_we=1 reg=%0d val=%h, required no link",
                   link_reg, link_val);
        end else begin
          link_t l;
          l = lq.pop_front();
          chk("link_reg", 32'(link_reg), 32'(l.r));
          chk("link_val", link_val, l.v);
        end
      end
    end
  end

  // One decode cycle; when a delay slot is accepted the following REDIRECT
  // cycle is spent with no instruction presented.
  task automatic apply(input bit v, input br_op_t op, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, input logic [25:0] ji, input logic [4:0] rd);
    bit redirect_next;
    link_t l;
    redir_t r;
    redirect_next = 0;
    instr_valid = v;
    br_op       = op;
    instr_pc    = pc;
    rs_val      = rs;
    rt_val      = rt;
    imm16       = imm;
    jidx        = ji;
    rd_idx      = rd;
    @(posedge clk);
    if (v && !mhalt) begin
      if (!mslot) begin
        if (m_link(op)) begin
          l.r = (op == JALR) ? rd : 5'd31;
          l.v = pc + 32'd8;
          lq.push_back(l);
        end
        if (m_taken(op, rs, rt)) begin
          mslot = 1;
          mcode = m_code(op);
          mtgt  = m_target(op, pc, rs, imm, ji);
        end
      end else begin
        if (op != NONE) exp_slot_err = 1;
        r.code = mcode;
        r.tgt  = mtgt;
        rq.push_back(r);
        mslot = 0;
        redirect_next = 1;
      end
    end
    #1;
    instr_valid = 1'b0;
    br_op       = NONE;
    if (redirect_next) begin
      @(posedge clk);
      if (mcode == 2'd3 && mtgt == HA) begin
        mhalt      = 1;
        exp_halted = 1;
      end
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, NONE, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc_ctrl"}, 32'(pc_ctrl), 32'd0);
    chk({tag, "_pc_in"}, pc_in, RV);
    chk({tag, "_link_we"}, 32'(link_we), 32'd0);
    chk({tag, "_link_reg"}, 32'(link_reg), 32'd0);
    chk({tag, "_link_val"}, link_val, 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_slot_err"}, 32'(slot_err), 32'd0);
  endtask

  task automatic model_reset();
    rq.delete();
    lq.delete();
    mslot        = 0;
    mhalt        = 0;
    exp_slot_err = 0;
    exp_halted   = 0;
  endtask

  initial begin
    br_op_t      op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    bit          v;

    // Power-on reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    #3 rst_n = 1'b1;
    idle(1);

    // BEQ taken with back-to-back delay slot
    apply(1, BEQ, 32'hBFC00010, 32'd5, 32'd5, 16'h0004, '0, '0);
    apply(1, NONE, 32'hBFC00014, '0, '0, '0, '0, '0);
    idle(2);

    // BNE not taken
    apply(1, BNE, 32'hBFC00030, 32'd7, 32'd7, 16'h0040, '0, '0);
    idle(2);

    // JAL with link
    apply(1, JAL, 32'hBFC00100, '0, '0, '0, 26'h0000040, '0);
    apply(1, NONE, 32'hBFC00104, '0, '0, '0, '0, '0);
    idle(1);

    // BLTZ with negative rs and backward offset
    apply(1, BLTZ, 32'hBFC00020, 32'h80000000, '0, 16'hFFFF, '0, '0);
    apply(1, NONE, 32'hBFC00024, '0, '0, '0, '0, '0);
    idle(1);

    // Delay slot arriving late and holding a branch
    apply(1, BEQ, 32'hBFC00200, 32'd1, 32'd1, 16'h0010, '0, '0);
    idle(3);
    apply(1, BEQ, 32'hBFC00204, 32'd2, 32'd2, 16'h0100, '0, '0);
    idle(2);

    // Not-taken conditional link still writes
    apply(1, BGEZAL, 32'hBFC00300, 32'h80000000, '0, 16'h0008, '0, '0);
    idle(1);
    apply(1, JALR, 32'hBFC00400, 32'h00400000, '0, '0, '0, 5'd9);
    apply(1, NONE, 32'hBFC00404, '0, '0, '0, '0, '0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = br_op_t'($urandom_range(0, 12));
      rs = $urandom;
      rt = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      case ($urandom_range(0, 7))
        0: rs = 32'h00000000;
        1: rs = 32'h80000000;
        2: rs = 32'h7FFFFFFF;
        3: rs = 32'hFFFFFFFF;
        default: ;
      endcase
      if ((op == JR || op == JALR) && rs == HA) rs = 32'h00000004;
      if (mslot && $urandom_range(0, 3) != 0) op = NONE;
      pc = $urandom & 32'hFFFFFFFC;
      v  = ($urandom_range(0, 3) != 0);
      apply(v, op, pc, rs, rt, 16'($urandom), 26'($urandom), 5'($urandom));
    end
    while (mslot) apply(1, NONE, 32'hBFC00500, '0, '0, '0, '0, '0);
    idle(2);

    // Register jump to HALT_ADDR, then inputs ignored
    apply(1, JR, 32'hBFC00600, HA, '0, '0, '0, '0);
    apply(1, NONE, 32'hBFC00604, '0, '0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      apply(1, br_op_t'($urandom_range(1, 12)), $urandom, $urandom, $urandom,
            16'($urandom), 26'($urandom), 5'($urandom));
    end

    // Reset leaves HALT
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("halt_exit");
    @(posedge clk);
    #4 rst_n = 1'b1;
    idle(1);

    // Build non-reset output state, then reset in the middle of SLOT
    apply(1, JAL, 32'hBFC00700, '0, '0, '0, 26'h0000123, '0);
    apply(1, BNE, 32'hBFC00704, 32'd1, 32'd2, 16'h0004, '0, '0);
    idle(1);
    apply(1, BEQ, 32'hBFC00800, 32'd3, 32'd3, 16'h0020, '0, '0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals("mid_slot");
    @(posedge clk);
    #4 rst_n = 1'b1;
    idle(1);
    apply(1, NONE, 32'hBFC00804, '0, '0, '0, '0, '0);
    idle(3);
    apply(1, BGTZ, 32'hBFC00900, 32'd1, '0, 16'h8000, '0, '0);
    apply(1, NONE, 32'hBFC00904, '0, '0, '0, '0, '0);
    idle(2);

    chk("redirects_outstanding", 32'(rq.size()), 32'd0);
    chk("links_outstanding", 32'(lq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
